// File: rtl/datapath_sequencer_if.sv
// Control/status bundle between the y/s datapath sequencer and its user.
// The slave modport is the sequencer side; master is the requester/datapath side.
interface datapath_sequencer_if;
  logic [1:0] on;
  logic       start;
  logic       tick;
  logic       y_inc;
  logic [1:0] regime;
  logic       active;
  logic       done;
  logic [1:0] y_select_next;
  logic [1:0] s_step;
  logic       s_add;
  logic       s_zero;
  logic       s_en;
  logic       y_en;
  logic       y_store_x;

  modport master (
    output on, start, tick, y_inc,
    input  regime, active, done, y_select_next,
    input  s_step, s_add, s_zero, s_en, y_en, y_store_x
  );

  modport slave (
    input  on, start, tick, y_inc,
    output regime, active, done, y_select_next,
    output s_step, s_add, s_zero, s_en, y_en, y_store_x
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Sequencer for the shared y/s datapath. One registered state machine runs
// the ELIST (s = 6,4,2,0 with a hold timer), CNT (s counts mod 3, carries
// into y on tick) and UPDATE (y <= x, s <= 0) regimes, with a start-arm
// interlock and a one-cycle done pulse.
module datapath_sequencer #(
  parameter int unsigned HOLD = 3
) (
  input logic                  clk,
  input logic                  rst,
  datapath_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    EL_LOAD,
    EL_WAIT,
    EL_SUB,
    CNT_RUN,
    UP_LOAD,
    UP_CLR,
    DONE
  } state_t;

  localparam logic [3:0] HOLD_CYC = 4'(HOLD);

  state_t     state;
  logic [3:0] timer;
  logic [1:0] index;
  logic       arm;
  logic [1:0] regime_q;

  // State, hold timer, ELIST index, start-arm flag and latched regime.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      timer    <= '0;
      index    <= '0;
      arm      <= 1'b0;
      regime_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arm && bus.start && (bus.on != 2'd0)) begin
            regime_q <= bus.on;
            index    <= '0;
            case (bus.on)
              2'd1:    state <= EL_LOAD;
              2'd2:    state <= CNT_RUN;
              default: state <= UP_LOAD;
            endcase
          end else if (!bus.start) begin
            arm <= 1'b1;
          end
        end
        EL_LOAD: begin
          timer <= HOLD_CYC;
          state <= EL_WAIT;
        end
        // A loaded value of 0 or 1 both give a single wait cycle, so HOLD=0
        // still spends one cycle here.
        EL_WAIT: begin
          if (timer <= 4'd1) begin
            timer <= '0;
            if (index != 2'd3) begin
              state <= EL_SUB;
            end else begin
              arm   <= 1'b0;
              state <= DONE;
            end
          end else begin
            timer <= timer - 4'd1;
          end
        end
        EL_SUB: begin
          index <= index + 2'd1;
          timer <= HOLD_CYC;
          state <= EL_WAIT;
        end
        CNT_RUN: begin
          if (!bus.start) begin
            arm   <= 1'b0;
            state <= DONE;
          end
        end
        UP_LOAD: state <= UP_CLR;
        UP_CLR: begin
          arm   <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          regime_q <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.regime = regime_q;

  // Command and status decode from the current state; CNT_RUN also looks at
  // start/tick/y_inc so each tick cycle updates the datapath at the next edge.
  always_comb begin
    bus.active        = 1'b0;
    bus.done          = 1'b0;
    bus.y_select_next = '0;
    bus.s_step        = '0;
    bus.s_add         = 1'b0;
    bus.s_zero        = 1'b0;
    bus.s_en          = 1'b0;
    bus.y_en          = 1'b0;
    bus.y_store_x     = 1'b0;
    case (state)
      EL_LOAD: begin
        bus.active = 1'b1;
        bus.s_en   = 1'b1;
        bus.s_zero = 1'b1;
        bus.s_step = 2'd2;
      end
      EL_WAIT: bus.active = 1'b1;
      EL_SUB: begin
        bus.active = 1'b1;
        bus.s_en   = 1'b1;
        bus.s_step = 2'd2;
      end
      CNT_RUN: begin
        bus.active = 1'b1;
        if (bus.start && bus.tick) begin
          bus.s_en  = 1'b1;
          bus.s_add = 1'b1;
          if (bus.y_inc) begin
            bus.s_zero        = 1'b1;
            bus.y_en          = 1'b1;
            bus.y_select_next = 2'd1;
          end else begin
            bus.s_step = 2'd1;
          end
        end
      end
      UP_LOAD: begin
        bus.active    = 1'b1;
        bus.y_en      = 1'b1;
        bus.y_store_x = 1'b1;
      end
      UP_CLR: begin
        bus.active = 1'b1;
        bus.s_en   = 1'b1;
        bus.s_zero = 1'b1;
        bus.s_add  = 1'b1;
      end
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Moore-style sequencer that owns the shared y/s datapath and drives its control lines for one of three regimes: list (ELIST), count (CNT) and load (UPDATE). The regime is selected by `on` and armed by a `start` edge. It replaces ad-hoc per-regime command decoding with a single registered state machine, a hold timer and a done handshake.

## Interface
- `HOLD`, default 3: extra cycles each ELIST value is held (legal 0..15).
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `on` input 2: regime request: 0 none, 1 ELIST, 2 CNT, 3 UPDATE.
- `start` input 1: level; a new operation needs a low→high arm (see Operation).
- `tick` input 1: count-rate strobe, used in CNT only.
- `y_inc` input 1: datapath status, 1 when s == 2 (next increment carries).
- `regime` output 2: regime of the running operation; 0 in IDLE.
- `active` output 1: 1 while an operation is running (not in IDLE/DONE).
- `done` output 1: one-cycle pulse in DONE.
- `y_select_next` output 2: y next-value select: 0 hold, 1 y+1.
- `s_step` output 2, `s_add` output 1, `s_zero` output 1, `s_en` output 1: s command.
- `y_en` output 1, `y_store_x` output 1: y command.

## Operation
- Datapath contract (3-bit s): when `s_en`=1, s ← (`s_zero` ? 0 : s) + (`s_add` ? +`s_step` : −`s_step`) mod 8. When `y_en`=1, y ← `y_store_x` ? x : (`y_select_next`==1 ? y+1 : y).
- All command outputs default to 0. They are asserted only in the states listed below.
- Arm flag: cleared by reset and on entry to DONE. Set in IDLE when `start`=0. An operation launches from IDLE only when arm=1, `start`=1 and `on`≠0. With `on`=0 the block stays in IDLE and no `done` pulse is issued.
- The launch latches `on` into `regime`. Changes on `on` after the launch are ignored.
- States:
  - IDLE.
  - EL_LOAD: `s_en`=1, `s_zero`=1, `s_add`=0, `s_step`=2, so s=6.
  - EL_WAIT: runs HOLD cycles. The timer loads HOLD on entry and the state exits when it reaches 0. With HOLD=0, EL_WAIT lasts 1 cycle.
  - EL_SUB: `s_en`=1, `s_zero`=0, `s_add`=0, `s_step`=2, so s−2. Increments a 2-bit index.
  - CNT_RUN.
  - UP_LOAD: `y_en`=1, `y_store_x`=1.
  - UP_CLR: `s_en`=1, `s_zero`=1, `s_add`=1, `s_step`=0, so s=0.
  - DONE.
- ELIST sequence: IDLE → EL_LOAD → EL_WAIT. From EL_WAIT, go to EL_SUB if index<3, else to DONE. EL_SUB returns to EL_WAIT. s takes the values 6, 4, 2, 0. Toggling `start` during ELIST is ignored.
- CNT sequence:
  - IDLE → CNT_RUN.
  - In CNT_RUN with `start`=0: go to DONE, no command that cycle. `start`=0 wins over `tick`.
  - With `start`=1 and `tick`=1 and `y_inc`=0: `s_en`=1, `s_add`=1, `s_step`=1 (s+1).
  - With `start`=1 and `tick`=1 and `y_inc`=1: `s_en`=1, `s_zero`=1, `s_add`=1, `s_step`=0 (s=0), plus `y_en`=1 and `y_select_next`=1 (y+1).
  - The result is that s counts mod 3 and carries into y.
- UPDATE sequence: IDLE → UP_LOAD → UP_CLR → DONE.
- DONE → IDLE unconditionally.
- Reset asserted at any point, including mid-operation, forces IDLE immediately. All outputs go to 0, arm=0, timer=0 and index=0. Datapath contents are not this block's concern.

## Timing
- All state, timer, index, arm and `regime` are registered. Commands and `active`/`done` are decoded from the current state, so a command shown in cycle N updates the datapath at edge N+1.
- Launch latency: `start` sampled high at edge E puts the first command state in cycle E+1.
- ELIST length: 1 + 4·(HOLD) + 3 cycles of `active`, then 1 DONE cycle. With HOLD=3 that is 16 active cycles. Each of 6, 4, 2 is visible for HOLD+1 cycles.
- UPDATE: 2 active cycles, then DONE.
- CNT: one s/y update per `tick` cycle. Exits 1 cycle after `start` is seen low.
- `regime` holds the latched mode through DONE and returns to 0 in IDLE.
- Back-to-back operations need at least one IDLE cycle with `start`=0. Holding `start` high through DONE never re-launches.

## Test plan
- ELIST, HOLD=3, s reset to 0, one-cycle `start` pulse with `on`=1 → s goes 6, 4, 2, 0. Each of 6, 4, 2 lasts 4 cycles. `active`=1 for 16 cycles. `done` pulses once. `regime`=1 throughout, then 0.
- CNT, `on`=2, `start` held high, 7 `tick` pulses from s=0, y=5 → s goes 1, 2, 0, 1, 2, 0, 1 and y=7. Dropping `start` in the same cycle as a tick gives no s change and DONE the next cycle.
- UPDATE, `on`=3, x=9, s=2 → `y_en`+`y_store_x` for 1 cycle, then the s-clear cycle. Result y=9, s=0, `done` on the 3rd cycle after launch.
- `start` held high across DONE, then `on` switched to 1 → no relaunch until `start` goes low for ≥1 IDLE cycle and rises again.
- `rst` driven low during ELIST EL_WAIT → all outputs 0 immediately, state IDLE, no `done`. After release, `start` already high does not launch.
- `on`=0 with a `start` pulse → no command outputs, `active`=0, no `done`. HOLD=0 ELIST completes in 8 active cycles.
